// File: rtl/phase_fet_drv.sv
// ---------------------------------------------------------------------------
// phase_fet_drv
//
// Consumer end of the commutation interface. Converts a PWM duty value and
// three per-phase mode selects into six FET gate drives (high/low side for
// the green, yellow and blue phases).
//
// Internals:
//   - 11-bit free-running PWM counter (2048-clock period) with a duty value
//     that is only latched at the end of a period, so mid-period duty
//     writes never produce a runt or stretched pulse.
//   - A registered PWM_synch strobe, one clock per period, that tells the
//     commutation block when to sample the hall sensors.
//   - Per-phase non-overlap logic. Any change of a phase's gate request
//     forces both of its FETs off for DEAD_TIME+1 clocks before the new
//     request is driven, so a shoot-through path can never be commanded.
//
// Parameters:
//   DEAD_TIME  clocks both FETs of a phase are held off around any
//              gate-request change (legal range 1..63)
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst_n      in   asynchronous active-low reset
//   duty       in   [10:0] PWM high time in clocks per 2048-clock period
//   selGrn     in   [1:0] green mode: 00 HIGH_Z, 01 rev_curr,
//                         10 frwd_curr, 11 regen brake
//   selYlw     in   [1:0] yellow mode, same encoding
//   selBlu     in   [1:0] blue mode, same encoding
//   highGrn    out  green high-side gate
//   lowGrn     out  green low-side gate
//   highYlw    out  yellow high-side gate
//   lowYlw     out  yellow low-side gate
//   highBlu    out  blue high-side gate
//   lowBlu     out  blue low-side gate
//   PWM_synch  out  one-clock pulse per PWM period (hall-sample strobe)
//
// Every output is driven straight from a flop; there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module phase_fet_drv #(
  parameter int DEAD_TIME = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] duty,
  input  logic [1:0]  selGrn,
  input  logic [1:0]  selYlw,
  input  logic [1:0]  selBlu,
  output logic        highGrn,
  output logic        lowGrn,
  output logic        highYlw,
  output logic        lowYlw,
  output logic        highBlu,
  output logic        lowBlu,
  output logic        PWM_synch
);

  localparam logic [5:0]  DEAD_MAX = 6'(DEAD_TIME);
  localparam logic [10:0] CNT_LAST = 11'h7FF;
  localparam logic [10:0] CNT_SYNC = 11'h001;

  // Phase mode encodings
  localparam logic [1:0] MODE_HIGHZ = 2'b00;
  localparam logic [1:0] MODE_REV   = 2'b01;
  localparam logic [1:0] MODE_FRWD  = 2'b10;
  localparam logic [1:0] MODE_BRAKE = 2'b11;

  // -------------------------------------------------------------------------
  // PWM generator
  // -------------------------------------------------------------------------
  logic [10:0] cnt_q,      cnt_d;
  logic [10:0] duty_lat_q, duty_lat_d;
  logic        pwm_q,      pwm_d;
  logic        synch_q,    synch_d;

  always_comb begin
    cnt_d      = cnt_q + 11'd1;
    duty_lat_d = duty_lat_q;
    // Latch the new duty only on the last count of a period so the next
    // period starts with a consistent high time.
    if (cnt_q == CNT_LAST) begin
      duty_lat_d = duty;
    end
    // Strict compare: duty 0 never goes high, 0x7FF leaves one low clock.
    pwm_d   = (cnt_q < duty_lat_q);
    synch_d = (cnt_q == CNT_SYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 11'd0;
      duty_lat_q <= 11'd0;
      pwm_q      <= 1'b0;
      synch_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_lat_q <= duty_lat_d;
      pwm_q      <= pwm_d;
      synch_q    <= synch_d;
    end
  end

  assign PWM_synch = synch_q;

  // -------------------------------------------------------------------------
  // Per-phase gate request and non-overlap logic
  // -------------------------------------------------------------------------
  // Index 0 = green, 1 = yellow, 2 = blue.
  logic [2:0][1:0] sel_w;
  logic [2:0][1:0] gate_w;

  assign sel_w[0] = selGrn;
  assign sel_w[1] = selYlw;
  assign sel_w[2] = selBlu;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_phase
      logic [1:0] req;          // {hi_req, lo_req}
      logic       change;
      logic [1:0] req_prev_q, req_prev_d;
      logic [5:0] dead_q,     dead_d;
      logic [1:0] gate_q,     gate_d;

      // Request decode. Brake shorts the phase to ground through the
      // low-side FET during the PWM on-time only.
      always_comb begin
        req = 2'b00;
        case (sel_w[gi])
          MODE_HIGHZ: req = 2'b00;
          MODE_REV:   req = {~pwm_q, pwm_q};
          MODE_FRWD:  req = {pwm_q, ~pwm_q};
          MODE_BRAKE: req = {1'b0, pwm_q};
          default:    req = 2'b00;
        endcase
      end

      // Any change restarts the dead-time count; the gates only follow the
      // request once it has been stable for a full dead-time window. A
      // request that toggles again before then is simply never driven.
      always_comb begin
        change     = (req != req_prev_q);
        req_prev_d = req;
        if (change) begin
          dead_d = 6'd0;
        end else if (dead_q == DEAD_MAX) begin
          dead_d = dead_q;
        end else begin
          dead_d = dead_q + 6'd1;
        end
        gate_d = ((dead_q == DEAD_MAX) && !change) ? req : 2'b00;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          req_prev_q <= 2'b00;
          dead_q     <= 6'd0;
          gate_q     <= 2'b00;
        end else begin
          req_prev_q <= req_prev_d;
          dead_q     <= dead_d;
          gate_q     <= gate_d;
        end
      end

      assign gate_w[gi] = gate_q;
    end
  endgenerate

  assign {highGrn, lowGrn} = gate_w[0];
  assign {highYlw, lowYlw} = gate_w[1];
  assign {highBlu, lowBlu} = gate_w[2];

endmodule

// File: tb/tb_phase_fet_drv.sv
// ---------------------------------------------------------------------------
// tb_phase_fet_drv
//
// Drives two copies of phase_fet_drv (DEAD_TIME = 32 and DEAD_TIME = 1) from
// the same stimulus. A behavioural model predicts the gate outputs from the
// rule "a gate follows its request only once that request has been constant
// for DEAD_TIME+2 consecutive cycles", using a history of past requests.
// ---------------------------------------------------------------------------
module tb_phase_fet_drv;

  localparam int DTA = 32;
  localparam int DTB = 1;
  localparam int HD  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] duty = 11'd0;
  logic [1:0]  selGrn = 2'b00;
  logic [1:0]  selYlw = 2'b00;
  logic [1:0]  selBlu = 2'b00;

  // Gate vectors ordered {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}
  wire [5:0] ga;
  wire [5:0] gb;
  wire       sa;
  wire       sb;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  phase_fet_drv #(.DEAD_TIME(DTA)) u_dta (
    .clk(clk), .rst_n(rst_n), .duty(duty),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .highGrn(ga[5]), .lowGrn(ga[4]), .highYlw(ga[3]), .lowYlw(ga[2]),
    .highBlu(ga[1]), .lowBlu(ga[0]), .PWM_synch(sa)
  );

  phase_fet_drv #(.DEAD_TIME(DTB)) u_dtb (
    .clk(clk), .rst_n(rst_n), .duty(duty),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .highGrn(gb[5]), .lowGrn(gb[4]), .highYlw(gb[3]), .lowYlw(gb[2]),
    .highBlu(gb[1]), .lowBlu(gb[0]), .PWM_synch(sb)
  );

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [10:0] m_cnt;
  logic [10:0] m_duty;
  logic        m_pwm;
  logic        m_synch;
  logic [1:0]  hist [0:2][0:HD-1];   // hist[ph][0] = request one cycle ago
  logic [5:0]  e_a;
  logic [5:0]  e_b;
  logic [1:0]  sel_arr [0:2];

  always_comb begin
    sel_arr[0] = selGrn;
    sel_arr[1] = selYlw;
    sel_arr[2] = selBlu;
  end

  function automatic logic [1:0] req_of(input logic [1:0] sel, input logic p);
    case (sel)
      2'b01:   return {~p, p};
      2'b10:   return {p, ~p};
      2'b11:   return {1'b0, p};
      default: return 2'b00;
    endcase
  endfunction

  // Gate value given the newest request r: r if r equals the last dt+1
  // requests as well, otherwise both off.
  function automatic logic [1:0] gate_of(input int ph, input int dt, input logic [1:0] r);
    for (int j = 0; j <= dt; j++) begin
      if (hist[ph][j] != r) return 2'b00;
    end
    return r;
  endfunction

  function automatic logic overlap(input logic [5:0] g);
    return (g[5] & g[4]) | (g[3] & g[2]) | (g[1] & g[0]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 11'd0;
      m_duty  <= 11'd0;
      m_pwm   <= 1'b0;
      m_synch <= 1'b0;
      e_a     <= 6'd0;
      e_b     <= 6'd0;
      for (int ph = 0; ph < 3; ph++)
        for (int j = 0; j < HD; j++) hist[ph][j] <= 2'b00;
    end else begin
      for (int ph = 0; ph < 3; ph++) begin
        for (int j = HD - 1; j > 0; j--) hist[ph][j] <= hist[ph][j-1];
        hist[ph][0] <= req_of(sel_arr[ph], m_pwm);
      end
      e_a <= {gate_of(0, DTA, req_of(sel_arr[0], m_pwm)),
              gate_of(1, DTA, req_of(sel_arr[1], m_pwm)),
              gate_of(2, DTA, req_of(sel_arr[2], m_pwm))};
      e_b <= {gate_of(0, DTB, req_of(sel_arr[0], m_pwm)),
              gate_of(1, DTB, req_of(sel_arr[1], m_pwm)),
              gate_of(2, DTB, req_of(sel_arr[2], m_pwm))};
      m_synch <= (m_cnt == 11'd1);
      m_pwm   <= ({21'd0, m_cnt} < {21'd0, m_duty});
      if (m_cnt == 11'h7FF) m_duty <= duty;
      m_cnt <= m_cnt + 11'd1;
    end
  end

  // Advance to the negedge at which the model counter equals tgt.
  task automatic wait_cnt(input logic [10:0] tgt, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 4200) begin
      @(negedge clk);
      n++;
      if (m_cnt == tgt) ok = 1'b1;
    end
  endtask

  // ------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------
  task automatic test_reset();
    int  first_n;
    int  period;
    int  fa;
    int  fb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ga, sa, gb, sb} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs act=%b req=%b", {ga, sa, gb, sb}, 14'd0);
    end
    rst_n = 1'b1;
    first_n = 0;
    for (int n = 1; n <= 10 && first_n == 0; n++) begin
      @(posedge clk); #1;
      if (sa) first_n = n;
    end
    checks++;
    if (first_n != 2) begin
      errors++; $display("FAIL reset_first_synch act=%0d req=2", first_n);
    end
    period = 0;
    for (int n = 1; n <= 3000 && period == 0; n++) begin
      @(posedge clk); #1;
      if (sa) period = n;
    end
    checks++;
    if (period != 2048) begin
      errors++; $display("FAIL synch_period act=%0d req=2048", period);
    end
    // Mid-run asynchronous reset with all phases driving.
    duty = 11'h400; selGrn = 2'b10; selYlw = 2'b11; selBlu = 2'b01;
    repeat (4200) @(negedge clk);
    checks++;
    if (ga === 6'd0) begin
      errors++; $display("FAIL prereset_active act=%b req=nonzero", ga);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({ga, sa, gb, sb} !== 14'd0) begin
      errors++; $display("FAIL midrun_reset act=%b req=%b", {ga, sa, gb, sb}, 14'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Blue in rev mode requests its high side from the first cycle.
    fa = 0; fb = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (fa == 0 && ga != 6'd0) fa = n;
      if (fb == 0 && gb != 6'd0) fb = n;
    end
    checks++;
    if (fa != DTA + 2) begin
      errors++; $display("FAIL post_reset_hold_a act=%0d req=%0d", fa, DTA + 2);
    end
    checks++;
    if (fb != DTB + 2) begin
      errors++; $display("FAIL post_reset_hold_b act=%0d req=%0d", fb, DTB + 2);
    end
  endtask

  task automatic test_pwm_steady();
    bit ok;
    int hia, loa, offa, runa, yba, hib, lob, offb, runb, ybb;
    logic pofa, pofb;
    duty = 11'h400; selGrn = 2'b10; selYlw = 2'b00; selBlu = 2'b00;
    wait_cnt(11'h7FF, ok);
    wait_cnt(11'h7FF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL steady_wait act=timeout req=cnt"); end
    {hia, loa, offa, runa, yba, hib, lob, offb, runb, ybb} = '0;
    pofa = 1'b0; pofb = 1'b0;
    for (int c = 0; c < 2048; c++) begin
      @(negedge clk);
      checks++;
      if ({ga, sa, gb, sb} !== {e_a, m_synch, e_b, m_synch}) begin
        errors++; $display("FAIL steady_model cyc=%0d act=%b req=%b", c, {ga, sa, gb, sb}, {e_a, m_synch, e_b, m_synch});
      end
      checks++;
      if (overlap(ga) || overlap(gb)) begin
        errors++; $display("FAIL steady_overlap cyc=%0d act=%b/%b req=no_overlap", c, ga, gb);
      end
      hia += ga[5]; loa += ga[4]; hib += gb[5]; lob += gb[4];
      yba += (ga[3:0] != 4'd0); ybb += (gb[3:0] != 4'd0);
      if (ga[5:4] == 2'b00) begin offa++; if (!pofa) runa++; end
      if (gb[5:4] == 2'b00) begin offb++; if (!pofb) runb++; end
      pofa = (ga[5:4] == 2'b00); pofb = (gb[5:4] == 2'b00);
    end
    checks++; if (hia != 991)  begin errors++; $display("FAIL steady_hi_a act=%0d req=991", hia); end
    checks++; if (loa != 991)  begin errors++; $display("FAIL steady_lo_a act=%0d req=991", loa); end
    checks++; if (offa != 66 || runa != 2) begin errors++; $display("FAIL steady_gap_a act=%0d/%0d req=66/2", offa, runa); end
    checks++; if (hib != 1022) begin errors++; $display("FAIL steady_hi_b act=%0d req=1022", hib); end
    checks++; if (lob != 1022) begin errors++; $display("FAIL steady_lo_b act=%0d req=1022", lob); end
    checks++; if (offb != 4 || runb != 2) begin errors++; $display("FAIL steady_gap_b act=%0d/%0d req=4/2", offb, runb); end
    checks++; if (yba != 0 || ybb != 0) begin errors++; $display("FAIL steady_idle_phases act=%0d/%0d req=0/0", yba, ybb); end
  endtask

  task automatic test_brake();
    bit ok;
    int hi_a, hi_b;
    int lo_a [3];
    int lo_b [3];
    duty = 11'h600; selGrn = 2'b11; selYlw = 2'b11; selBlu = 2'b11;
    wait_cnt(11'h7FF, ok);
    wait_cnt(11'h7FF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL brake_wait act=timeout req=cnt"); end
    hi_a = 0; hi_b = 0;
    for (int p = 0; p < 3; p++) begin lo_a[p] = 0; lo_b[p] = 0; end
    for (int c = 0; c < 2048; c++) begin
      @(negedge clk);
      checks++;
      if ({ga, sa, gb, sb} !== {e_a, m_synch, e_b, m_synch}) begin
        errors++; $display("FAIL brake_model cyc=%0d act=%b req=%b", c, {ga, sa, gb, sb}, {e_a, m_synch, e_b, m_synch});
      end
      checks++;
      if (overlap(ga) || overlap(gb)) begin
        errors++; $display("FAIL brake_overlap cyc=%0d act=%b/%b req=no_overlap", c, ga, gb);
      end
      hi_a += ga[5] + ga[3] + ga[1];
      hi_b += gb[5] + gb[3] + gb[1];
      for (int p = 0; p < 3; p++) begin
        lo_a[p] += ga[4 - 2*p];
        lo_b[p] += gb[4 - 2*p];
      end
    end
    checks++;
    if (hi_a != 0 || hi_b != 0) begin errors++; $display("FAIL brake_high act=%0d/%0d req=0/0", hi_a, hi_b); end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (lo_a[p] != 1503) begin errors++; $display("FAIL brake_lo_a ph=%0d act=%0d req=1503", p, lo_a[p]); end
      checks++;
      if (lo_b[p] != 1534) begin errors++; $display("FAIL brake_lo_b ph=%0d act=%0d req=1534", p, lo_b[p]); end
    end
  endtask

  task automatic test_duty_change();
    bit ok;
    int cur_a, cur_b, nxt_a, nxt_b;
    duty = 11'h400; selGrn = 2'b10; selYlw = 2'b00; selBlu = 2'b00;
    wait_cnt(11'h7FF, ok);
    wait_cnt(11'h7FF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL duty_wait act=timeout req=cnt"); end
    cur_a = 0; cur_b = 0; nxt_a = 0; nxt_b = 0;
    for (int c = 0; c < 4096; c++) begin
      @(negedge clk);
      checks++;
      if ({ga, sa, gb, sb} !== {e_a, m_synch, e_b, m_synch}) begin
        errors++; $display("FAIL duty_model cyc=%0d act=%b req=%b", c, {ga, sa, gb, sb}, {e_a, m_synch, e_b, m_synch});
      end
      checks++;
      if (overlap(ga) || overlap(gb)) begin
        errors++; $display("FAIL duty_overlap cyc=%0d act=%b/%b req=no_overlap", c, ga, gb);
      end
      if (c < 2048) begin cur_a += ga[5]; cur_b += gb[5]; end
      else begin nxt_a += ga[5]; nxt_b += gb[5]; end
      if (m_cnt == 11'h100 && c < 2048) duty = 11'h700;
    end
    checks++; if (cur_a != 991)  begin errors++; $display("FAIL duty_cur_a act=%0d req=991", cur_a); end
    checks++; if (cur_b != 1022) begin errors++; $display("FAIL duty_cur_b act=%0d req=1022", cur_b); end
    checks++; if (nxt_a != 1759) begin errors++; $display("FAIL duty_next_a act=%0d req=1759", nxt_a); end
    checks++; if (nxt_b != 1790) begin errors++; $display("FAIL duty_next_b act=%0d req=1790", nxt_b); end
  endtask

  task automatic test_sel_switch();
    bit ok;
    int fall_a, fall_b, rise_a, rise_b;
    duty = 11'h400; selGrn = 2'b10; selYlw = 2'b00; selBlu = 2'b00;
    wait_cnt(11'h7FF, ok);
    wait_cnt(11'h7FF, ok);
    wait_cnt(11'h200, ok);
    checks++;
    if (!ok || ga[5] !== 1'b1) begin
      errors++; $display("FAIL sel_setup act=%b req=highGrn_on", ga[5]);
    end
    selGrn = 2'b01;
    fall_a = 0; fall_b = 0; rise_a = 0; rise_b = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      checks++;
      if (overlap(ga) || overlap(gb)) begin
        errors++; $display("FAIL sel_overlap n=%0d act=%b/%b req=no_overlap", n, ga, gb);
      end
      if (fall_a == 0 && !ga[5]) fall_a = n;
      if (fall_b == 0 && !gb[5]) fall_b = n;
      if (rise_a == 0 && ga[4])  rise_a = n;
      if (rise_b == 0 && gb[4])  rise_b = n;
    end
    checks++; if (fall_a != 1) begin errors++; $display("FAIL sel_fall_a act=%0d req=1", fall_a); end
    checks++; if (fall_b != 1) begin errors++; $display("FAIL sel_fall_b act=%0d req=1", fall_b); end
    checks++; if (rise_a - fall_a != DTA + 1) begin errors++; $display("FAIL sel_gap_a act=%0d req=%0d", rise_a - fall_a, DTA + 1); end
    checks++; if (rise_b - fall_b != DTB + 1) begin errors++; $display("FAIL sel_gap_b act=%0d req=%0d", rise_b - fall_b, DTB + 1); end
  endtask

  task automatic test_short_pulse();
    bit ok;
    int hi_a, lo_a, hi_b, lo_b;
    duty = 11'h010; selGrn = 2'b00; selYlw = 2'b00; selBlu = 2'b10;
    wait_cnt(11'h7FF, ok);
    wait_cnt(11'h7FF, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL short_wait act=timeout req=cnt"); end
    hi_a = 0; lo_a = 0; hi_b = 0; lo_b = 0;
    for (int c = 0; c < 4096; c++) begin
      @(negedge clk);
      checks++;
      if ({ga, sa, gb, sb} !== {e_a, m_synch, e_b, m_synch}) begin
        errors++; $display("FAIL short_model cyc=%0d act=%b req=%b", c, {ga, sa, gb, sb}, {e_a, m_synch, e_b, m_synch});
      end
      checks++;
      if (overlap(ga) || overlap(gb)) begin
        errors++; $display("FAIL short_overlap cyc=%0d act=%b/%b req=no_overlap", c, ga, gb);
      end
      hi_a += ga[1]; lo_a += ga[0]; hi_b += gb[1]; lo_b += gb[0];
    end
    checks++; if (hi_a != 0)    begin errors++; $display("FAIL short_hi_a act=%0d req=0", hi_a); end
    checks++; if (lo_a != 3998) begin errors++; $display("FAIL short_lo_a act=%0d req=3998", lo_a); end
    checks++; if (hi_b != 28)   begin errors++; $display("FAIL short_hi_b act=%0d req=28", hi_b); end
    checks++; if (lo_b != 4060) begin errors++; $display("FAIL short_lo_b act=%0d req=4060", lo_b); end
  endtask

  task automatic test_random();
    int hold;
    int c;
    hold = 0;
    c = 0;
    while (c < 8000) begin
      if (hold == 0) begin
        duty   = 11'($urandom);
        if ($urandom_range(0, 3) == 0) duty = 11'($urandom_range(0, 40));
        selGrn = 2'($urandom);
        selYlw = 2'($urandom);
        selBlu = 2'($urandom);
        hold   = $urandom_range(1, 300);
      end
      @(negedge clk);
      hold--;
      c++;
      checks++;
      if ({ga, sa, gb, sb} !== {e_a, m_synch, e_b, m_synch}) begin
        errors++; $display("FAIL random_model cyc=%0d act=%b req=%b", c, {ga, sa, gb, sb}, {e_a, m_synch, e_b, m_synch});
      end
      checks++;
      if (overlap(ga) || overlap(gb)) begin
        errors++; $display("FAIL random_overlap cyc=%0d act=%b/%b req=no_overlap", c, ga, gb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pwm_steady();
    test_brake();
    test_duty_change();
    test_sel_switch();
    test_short_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
